nx_fifo_prefetch: RTL

Parametrised successor to the basic flop FIFO, with a prefetched, registered read port. Data is buffered in a DEPTH-entry flop array that feeds an output register; the read side uses a valid/ready handshake. Adds programmable almost-full and almost-empty flags, a sticky overflow flag, and correct pointer wrap for any non-power-of-two DEPTH. Used between pipeline stages where a module needs a flop-timed read port and early back-pressure.

---
 rtl/nx_fifo_prefetch_if.sv | 32 +++
 rtl/nx_fifo_prefetch.sv | 118 +++++++++++
 2 files changed

// File: rtl/nx_fifo_prefetch_if.sv
// rtl/nx_fifo_prefetch_if.sv - write/read/status bundle for the prefetching FIFO
interface nx_fifo_prefetch_if #(
   parameter int WIDTH = 83,
   parameter int CW    = 5
);
   logic             clear;
   logic             wen;
   logic [WIDTH-1:0] wdata;
   logic             full;
   logic             almost_full;
   logic             rd_valid;
   logic             rd_ready;
   logic [WIDTH-1:0] rdata;
   logic             empty;
   logic             almost_empty;
   logic [CW-1:0]    used_slots;
   logic [CW-1:0]    free_slots;
   logic             overflow;
   logic             overflow_sticky;

   modport master (
      output clear, wen, wdata, rd_ready,
      input  full, almost_full, rd_valid, rdata, empty, almost_empty,
             used_slots, free_slots, overflow, overflow_sticky
   );

   modport slave (
      input  clear, wen, wdata, rd_ready,
      output full, almost_full, rd_valid, rdata, empty, almost_empty,
             used_slots, free_slots, overflow, overflow_sticky
   );
endinterface

// File: rtl/nx_fifo_prefetch.sv
// rtl/nx_fifo_prefetch.sv - flop FIFO with registered prefetch read port
module nx_fifo_prefetch #(
   parameter int DEPTH      = 25,
   parameter int WIDTH      = 83,
   parameter int AF_THRESH  = DEPTH - 1,
   parameter int AE_THRESH  = 1,
   parameter bit DATA_RESET = 1'b1,
   parameter int CW         = $clog2(DEPTH + 2)
) (
   input  logic               clk,
   input  logic               rst_n,
   nx_fifo_prefetch_if.slave  bus
);
   localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CAP  = CW'(DEPTH + 1);
   localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);
   localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_rptr;
   logic [PW-1:0]    r_wptr;
   logic [CW-1:0]    r_cnt;
   logic             r_valid;
   logic [WIDTH-1:0] r_rdata;
   logic             r_ovf;
   logic             r_sticky;

   logic [CW-1:0]    w_used;
   logic             w_full;
   logic             w_wr_acc;
   logic             w_drop;
   logic             w_pop;
   logic             w_load;
   logic             w_arr_ne;
   logic             w_head_mv;
   logic             w_bypass;
   logic             w_arr_wr;
   logic [CW-1:0]    w_cnt_nxt;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == PMAX) ? '0 : p + PW'(1);
   endfunction

   assign w_used    = r_cnt + {{(CW-1){1'b0}}, r_valid};
   assign w_full    = (w_used == CAP);
   assign w_wr_acc  = bus.wen && !w_full && !bus.clear;
   assign w_drop    = bus.wen &&  w_full && !bus.clear;
   assign w_pop     = r_valid && bus.rd_ready;
   assign w_load    = !r_valid || w_pop;
   assign w_arr_ne  = (r_cnt != '0);
   assign w_head_mv = w_load && w_arr_ne && !bus.clear;
   // Bypass only when nothing older is queued, so ordering is preserved.
   assign w_bypass  = w_load && !w_arr_ne && w_wr_acc;
   assign w_arr_wr  = w_wr_acc && !w_bypass;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_arr_wr && !w_head_mv)
         w_cnt_nxt = r_cnt + CW'(1);
      else if (!w_arr_wr && w_head_mv)
         w_cnt_nxt = r_cnt - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (w_arr_wr)
         r_mem[r_wptr] <= bus.wdata;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rptr   <= '0;
         r_wptr   <= '0;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_rdata  <= '0;
         r_ovf    <= 1'b0;
         r_sticky <= 1'b0;
      end else if (bus.clear) begin
         r_rptr   <= '0;
         r_wptr   <= '0;
         r_cnt    <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_sticky <= 1'b0;
         if (DATA_RESET)
            r_rdata <= '0;
      end else begin
         r_ovf <= w_drop;
         if (w_drop)
            r_sticky <= 1'b1;
         if (w_arr_wr)
            r_wptr <= f_inc(r_wptr);
         if (w_head_mv)
            r_rptr <= f_inc(r_rptr);
         r_cnt <= w_cnt_nxt;
         if (w_load)
            r_valid <= w_arr_ne || w_wr_acc;
         if (w_head_mv)
            r_rdata <= r_mem[r_rptr];
         else if (w_bypass)
            r_rdata <= bus.wdata;
         else if (w_pop && DATA_RESET)
            r_rdata <= '0;
      end
   end

   assign bus.full            = w_full;
   assign bus.almost_full     = (w_used >= AF_C);
   assign bus.empty           = (w_used == '0);
   assign bus.almost_empty    = (w_used <= AE_C);
   assign bus.rd_valid        = r_valid;
   assign bus.rdata           = r_rdata;
   assign bus.used_slots      = w_used;
   assign bus.free_slots      = CAP - w_used;
   assign bus.overflow        = r_ovf;
   assign bus.overflow_sticky = r_sticky;
endmodule
